// File: rtl/mac_lane_sequencer_if.sv
// Command, operand-stream, lane and result signals of one MAC lane sequencer.
// With MAC_SEQ_MONITOR_EN defined, also carries the NaN/Inf result flags and sticky monitor outputs.
interface mac_lane_sequencer_if #(
  parameter int MAC_W_ELEMENT = 10,
  parameter int N_ELEM        = 64,
  parameter int W_CNT         = 12
);
  localparam int W_DATA     = MAC_W_ELEMENT * N_ELEM;
  localparam int W_LANE_IFM = W_DATA + N_ELEM + 2;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [7:0]            cmd_instr;
  logic [W_CNT-1:0]      cmd_inter_len;
  logic [W_CNT-1:0]      cmd_group_len;
  logic [W_CNT-1:0]      cmd_accum_cnt;

  logic                  ifm_valid;
  logic                  ifm_ready;
  logic [W_DATA-1:0]     ifm_data;
  logic [N_ELEM-1:0]     ifm_elem_valid;
  logic                  wfm_valid;
  logic                  wfm_ready;
  logic [W_DATA-1:0]     wfm_data;

  logic [7:0]            lane_instr;
  logic                  lane_valid;
  logic [W_LANE_IFM-1:0] lane_ifm;
  logic [W_DATA-1:0]     lane_wfm;
  logic                  lane_ofm_valid;
  logic [31:0]           lane_ofm;

  logic                  res_valid;
  logic                  res_ready;
  logic [31:0]           res_data;
  logic                  cmd_done;

`ifdef MAC_SEQ_MONITOR_EN
  logic                  lane_is_nan;
  logic                  lane_is_inf;
  logic                  mon_nan;
  logic                  mon_inf;
`endif

  modport slave (
    input  cmd_valid, cmd_instr, cmd_inter_len, cmd_group_len, cmd_accum_cnt,
    output cmd_ready,
    input  ifm_valid, ifm_data, ifm_elem_valid,
    output ifm_ready,
    input  wfm_valid, wfm_data,
    output wfm_ready,
    output lane_instr, lane_valid, lane_ifm, lane_wfm,
    input  lane_ofm_valid, lane_ofm,
`ifdef MAC_SEQ_MONITOR_EN
    input  lane_is_nan, lane_is_inf,
    output mon_nan, mon_inf,
`endif
    output res_valid, res_data,
    input  res_ready,
    output cmd_done
  );

  modport master (
    output cmd_valid, cmd_instr, cmd_inter_len, cmd_group_len, cmd_accum_cnt,
    input  cmd_ready,
    output ifm_valid, ifm_data, ifm_elem_valid,
    input  ifm_ready,
    output wfm_valid, wfm_data,
    input  wfm_ready,
    input  lane_instr, lane_valid, lane_ifm, lane_wfm,
    output lane_ofm_valid, lane_ofm,
`ifdef MAC_SEQ_MONITOR_EN
    output lane_is_nan, lane_is_inf,
    input  mon_nan, mon_inf,
`endif
    input  res_valid, res_data,
    output res_ready,
    input  cmd_done
  );
endinterface

// File: rtl/mac_lane_sequencer.sv
// Sequences one MAC lane: joins IFM/WFM beats, tags loop ends, credit-limits accumulations, buffers results.
// Optional MAC_SEQ_MONITOR_EN adds sticky NaN/Inf result monitors. lane_ifm = {accum_end, inter_end, elem_valid, data}.
//   state | meaning
//   IDLE  | waiting for a command, cmd_ready high
//   RUN   | issuing lane beats
//   DRAIN | all beats issued, waiting for every result to be popped
//   DONE  | one-cycle completion pulse
module mac_lane_sequencer #(
  parameter int MAC_W_ELEMENT   = 10,
  parameter int N_ELEM          = 64,
  parameter int W_CNT           = 12,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                 clk,
  input logic                 rst,
  mac_lane_sequencer_if.slave bus
);
  localparam int W_DATA     = MAC_W_ELEMENT * N_ELEM;
  localparam int W_LANE_IFM = W_DATA + N_ELEM + 2;
  localparam int PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CRED_W     = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [7:0]            instr_q;
  logic [W_CNT-1:0]      len_l_q, len_g_q, len_a_q;
  logic [W_CNT-1:0]      beat_q, group_q, acc_q, pop_cnt_q;
  logic [CRED_W-1:0]     credits_q;
  logic                  lane_valid_q;
  logic [W_LANE_IFM-1:0] lane_ifm_q;
  logic [W_DATA-1:0]     lane_wfm_q;
  logic [31:0]           fifo_mem [MAX_OUTSTANDING];
  logic [PTR_W:0]        wr_ptr_q, rd_ptr_q;

  logic cmd_accept, cmd_zero, cmd_ready, cmd_done, fire;
  logic inter_end, accum_end, last_accum, credit_ok;
  logic fifo_empty, fifo_full, res_pop, fifo_push;

  assign cmd_accept = (state_q == S_IDLE) && bus.cmd_valid;
  assign cmd_zero   = (bus.cmd_inter_len == '0) || (bus.cmd_group_len == '0) ||
                      (bus.cmd_accum_cnt == '0);
  assign credit_ok  = credits_q < CRED_W'(MAX_OUTSTANDING);
  assign inter_end  = (beat_q == len_l_q - W_CNT'(1));
  assign accum_end  = inter_end && (group_q == len_g_q - W_CNT'(1));
  assign last_accum = (acc_q == len_a_q - W_CNT'(1));

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    fire      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = cmd_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        fire = bus.ifm_valid && bus.wfm_valid && credit_ok;
        if (fire && accum_end && last_accum) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (fifo_empty && (pop_cnt_q == len_a_q)) state_d = S_DONE;
      end
      S_DONE: begin
        cmd_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Command latch and the beat -> group -> accumulation loop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      len_l_q <= '0;
      len_g_q <= '0;
      len_a_q <= '0;
      beat_q  <= '0;
      group_q <= '0;
      acc_q   <= '0;
    end else if (cmd_accept) begin
      instr_q <= bus.cmd_instr;
      len_l_q <= bus.cmd_inter_len;
      len_g_q <= bus.cmd_group_len;
      len_a_q <= bus.cmd_accum_cnt;
      beat_q  <= '0;
      group_q <= '0;
      acc_q   <= '0;
    end else if (fire) begin
      if (accum_end) begin
        beat_q  <= '0;
        group_q <= '0;
        acc_q   <= acc_q + W_CNT'(1);
      end else if (inter_end) begin
        beat_q  <= '0;
        group_q <= group_q + W_CNT'(1);
      end else begin
        beat_q  <= beat_q + W_CNT'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_valid_q <= 1'b0;
      lane_ifm_q   <= '0;
      lane_wfm_q   <= '0;
    end else begin
      lane_valid_q <= fire;
      if (fire) begin
        lane_ifm_q <= {accum_end, inter_end, bus.ifm_elem_valid, bus.ifm_data};
        lane_wfm_q <= bus.wfm_data;
      end
    end
  end

  // A credit is held from the accum_end beat until its result leaves the FIFO.
  always_ff @(posedge clk) begin
    if (rst) credits_q <= '0;
    else     credits_q <= credits_q + CRED_W'(fire && accum_end) - CRED_W'(res_pop);
  end

  always_ff @(posedge clk) begin
    if (rst)             pop_cnt_q <= '0;
    else if (cmd_accept) pop_cnt_q <= '0;
    else if (res_pop && (state_q == S_RUN || state_q == S_DRAIN))
      pop_cnt_q <= pop_cnt_q + W_CNT'(1);
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign res_pop    = !fifo_empty && bus.res_ready;
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign fifo_push  = bus.lane_ofm_valid && (!fifo_full || res_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (fifo_push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (res_pop)   rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= bus.lane_ofm;
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(bus.lane_ofm_valid && fifo_full && !res_pop));

`ifdef MAC_SEQ_MONITOR_EN
  logic mon_nan_q, mon_inf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mon_nan_q <= 1'b0;
      mon_inf_q <= 1'b0;
    end else begin
      mon_nan_q <= (mon_nan_q && !cmd_accept) || (bus.lane_ofm_valid && bus.lane_is_nan);
      mon_inf_q <= (mon_inf_q && !cmd_accept) || (bus.lane_ofm_valid && bus.lane_is_inf);
    end
  end

  assign bus.mon_nan = mon_nan_q;
  assign bus.mon_inf = mon_inf_q;
`endif

  assign bus.cmd_ready  = cmd_ready;
  assign bus.cmd_done   = cmd_done;
  assign bus.ifm_ready  = fire;
  assign bus.wfm_ready  = fire;
  assign bus.lane_instr = instr_q;
  assign bus.lane_valid = lane_valid_q;
  assign bus.lane_ifm   = lane_ifm_q;
  assign bus.lane_wfm   = lane_wfm_q;
  assign bus.res_valid  = !fifo_empty;
  assign bus.res_data   = fifo_empty ? 32'h0 : fifo_mem[rd_ptr_q[PTR_W-1:0]];
endmodule

// File: tb/tb_mac_lane_sequencer.sv
// Directed scoreboard bench for mac_lane_sequencer: expected beats/results queued at stimulus time, popped at DUT output.
module tb_mac_lane_sequencer;
  localparam int MAC_W_ELEMENT   = 10;
  localparam int N_ELEM          = 64;
  localparam int W_CNT           = 12;
  localparam int MAX_OUTSTANDING = 4;
  localparam int W_DATA          = MAC_W_ELEMENT * N_ELEM;
  localparam int W_LIFM          = W_DATA + N_ELEM + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_lane_sequencer_if #(.MAC_W_ELEMENT(MAC_W_ELEMENT), .N_ELEM(N_ELEM), .W_CNT(W_CNT)) bus_if ();

  mac_lane_sequencer #(
    .MAC_W_ELEMENT(MAC_W_ELEMENT), .N_ELEM(N_ELEM), .W_CNT(W_CNT),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  typedef struct { int idx; bit ie; bit ae; } beat_t;
  beat_t       exp_beats[$];
  logic [31:0] exp_res[$];

  int checks = 0, failures = 0, cyc = 0;
  int len_l, len_g, b_m, g_m, ifm_idx;
  bit strm_on, wfm_toggle, lane_auto;
  int pending, hold_until, res_seq;
  int n_beats, n_ie, n_ae, n_pops, n_done, n_fire;
  int first_beat_cyc, last_beat_cyc, acc_cyc, done_cyc;

  function automatic logic [W_DATA-1:0] mk_data(input int idx, input int mul);
    logic [W_DATA-1:0] d;
    for (int e = 0; e < N_ELEM; e++)
      d[e*MAC_W_ELEMENT +: MAC_W_ELEMENT] = MAC_W_ELEMENT'(idx * mul + e * 13 + 5);
    return d;
  endfunction

  function automatic logic [N_ELEM-1:0] mk_ev(input int idx);
    logic [N_ELEM-1:0] v;
    for (int e = 0; e < N_ELEM; e++) v[e] = ((idx + e) % 3) != 0;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [W_LIFM-1:0] obs, input logic [W_LIFM-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive model inputs, observe at negedge+1, then advance to the next negedge.
  task automatic tick();
    beat_t b;
    bit ie, ae;
    cyc++;
    bus_if.ifm_valid      = strm_on;
    bus_if.wfm_valid      = strm_on && (!wfm_toggle || (cyc % 2) == 0);
    bus_if.ifm_data       = mk_data(ifm_idx, 7);
    bus_if.ifm_elem_valid = mk_ev(ifm_idx);
    bus_if.wfm_data       = mk_data(ifm_idx, 11);
    if (lane_auto) begin
      bus_if.lane_ofm_valid = 1'b0;
      if (pending > 0 && cyc >= hold_until) begin
        bus_if.lane_ofm_valid = 1'b1;
        bus_if.lane_ofm       = 32'h1000 + res_seq;
        exp_res.push_back(32'h1000 + res_seq);
        res_seq++;
        pending--;
      end
    end
    #1;
    if (bus_if.lane_valid === 1'b1) begin
      if (exp_beats.size() == 0) chk("lane_beat_unexpected", bus_if.lane_valid, 1'b0);
      else begin
        b = exp_beats.pop_front();
        chk("lane_ifm", bus_if.lane_ifm, {b.ae, b.ie, mk_ev(b.idx), mk_data(b.idx, 7)});
        chk("lane_wfm", bus_if.lane_wfm, mk_data(b.idx, 11));
        if (b.ae) pending++;
      end
      if (first_beat_cyc < 0) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
      n_beats++;
      n_ie += int'(bus_if.lane_ifm[W_LIFM-2]);
      n_ae += int'(bus_if.lane_ifm[W_LIFM-1]);
    end
    chk("ready_pair", bus_if.ifm_ready, bus_if.wfm_ready);
    if (bus_if.ifm_ready === 1'b1) begin
      chk("fire_needs_valid", bus_if.ifm_valid & bus_if.wfm_valid, 1'b1);
      ie = (b_m == len_l - 1);
      ae = ie && (g_m == len_g - 1);
      exp_beats.push_back('{ifm_idx, ie, ae});
      if (ie) begin
        b_m = 0;
        g_m = ae ? 0 : g_m + 1;
      end else b_m++;
      ifm_idx++;
      n_fire++;
    end
    if (bus_if.res_valid === 1'b1 && bus_if.res_ready === 1'b1) begin
      if (exp_res.size() == 0) chk("res_unexpected", bus_if.res_valid, 1'b0);
      else chk("res_data", bus_if.res_data, exp_res.pop_front());
      n_pops++;
    end
    if (bus_if.cmd_valid === 1'b1 && bus_if.cmd_ready === 1'b1) begin
      acc_cyc = cyc;
      len_l   = int'(bus_if.cmd_inter_len);
      len_g   = int'(bus_if.cmd_group_len);
      b_m     = 0;
      g_m     = 0;
    end
    if (bus_if.cmd_done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    @(negedge clk);
  endtask

  task automatic start_cmd(input logic [7:0] instr, input int l, input int g, input int a);
    n_beats = 0; n_ie = 0; n_ae = 0; n_pops = 0; n_done = 0; n_fire = 0; pending = 0;
    first_beat_cyc = -1; last_beat_cyc = -1; acc_cyc = -1; done_cyc = -1;
    bus_if.cmd_valid     = 1'b1;
    bus_if.cmd_instr     = instr;
    bus_if.cmd_inter_len = W_CNT'(l);
    bus_if.cmd_group_len = W_CNT'(g);
    bus_if.cmd_accum_cnt = W_CNT'(a);
    tick();
    bus_if.cmd_valid = 1'b0;
    chk("cmd_accepted", acc_cyc, cyc);
    tick();
    chk("lane_instr", bus_if.lane_instr, instr);
  endtask

  task automatic wait_done(input int budget);
    int n = budget;
    while (n_done == 0 && n > 0) begin
      tick();
      n--;
    end
    tick();
    chk("cmd_done_once", n_done, 1);
    chk("cmd_ready_after_done", bus_if.cmd_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_if.cmd_valid = 1'b0; bus_if.cmd_instr = '0;
    bus_if.cmd_inter_len = '0; bus_if.cmd_group_len = '0; bus_if.cmd_accum_cnt = '0;
    bus_if.ifm_valid = 1'b0; bus_if.ifm_data = '0; bus_if.ifm_elem_valid = '0;
    bus_if.wfm_valid = 1'b0; bus_if.wfm_data = '0;
    bus_if.lane_ofm_valid = 1'b0; bus_if.lane_ofm = '0; bus_if.res_ready = 1'b0;
`ifdef MAC_SEQ_MONITOR_EN
    bus_if.lane_is_nan = 1'b0; bus_if.lane_is_inf = 1'b0;
`endif
    strm_on = 0; wfm_toggle = 0; lane_auto = 0; pending = 0; hold_until = 0; res_seq = 0;
    ifm_idx = 0; len_l = 1; len_g = 1; b_m = 0; g_m = 0;
    n_beats = 0; n_ie = 0; n_ae = 0; n_pops = 0; n_done = 0; n_fire = 0;
    first_beat_cyc = -1; last_beat_cyc = -1; acc_cyc = -1; done_cyc = -1;
    @(negedge clk);
    repeat (3) tick();
    chk("rst_cmd_ready", bus_if.cmd_ready, 1'b1);
    chk("rst_lane_valid", bus_if.lane_valid, 1'b0);
    chk("rst_lane_ifm", bus_if.lane_ifm, '0);
    chk("rst_lane_wfm", bus_if.lane_wfm, '0);
    chk("rst_lane_instr", bus_if.lane_instr, '0);
    chk("rst_res_valid", bus_if.res_valid, 1'b0);
    chk("rst_res_data", bus_if.res_data, '0);
    chk("rst_cmd_done", bus_if.cmd_done, 1'b0);
    chk("rst_ifm_ready", bus_if.ifm_ready, 1'b0);
    rst = 1'b0;
    tick();

    // L=4 G=2 A=1, free-flowing streams
    strm_on = 1; lane_auto = 1; bus_if.res_ready = 1'b1;
    start_cmd(8'h5A, 4, 2, 1);
    chk("cmd_ready_in_run", bus_if.cmd_ready, 1'b0);
    wait_done(60);
    chk("t1_beats", n_beats, 8);
    chk("t1_consecutive", last_beat_cyc - first_beat_cyc, 7);
    chk("t1_inter_ends", n_ie, 2);
    chk("t1_accum_ends", n_ae, 1);
    chk("t1_results", n_pops, 1);

    // L=1 G=1 A=8, lane silent for 20 cycles: credit limit stalls issue at 4
    hold_until = cyc + 20;
    start_cmd(8'h33, 1, 1, 8);
    repeat (14) tick();
    chk("t2_beats_capped", n_beats, MAX_OUTSTANDING);
    chk("t2_fires_capped", n_fire, MAX_OUTSTANDING);
    chk("t2_ifm_stalled", bus_if.ifm_ready, 1'b0);
    wait_done(200);
    hold_until = 0;
    chk("t2_beats", n_beats, 8);
    chk("t2_results", n_pops, 8);

    // WFM valid toggling every cycle
    wfm_toggle = 1;
    start_cmd(8'hC1, 3, 2, 2);
    wait_done(200);
    wfm_toggle = 0;
    chk("t3_beats", n_beats, 12);
    chk("t3_inter_ends", n_ie, 4);
    chk("t3_accum_ends", n_ae, 2);
    chk("t3_results", n_pops, 2);

    // Full FIFO with res_ready low, then a same-cycle push and pop
    lane_auto = 0; bus_if.res_ready = 1'b0;
    start_cmd(8'h0F, 1, 1, 5);
    for (int k = 0; k < 20 && n_beats < 4; k++) tick();
    repeat (3) tick();
    chk("t4_fires_capped", n_fire, 4);
    for (int v = 0; v < 4; v++) begin
      bus_if.lane_ofm_valid = 1'b1;
      bus_if.lane_ofm       = 32'hA + v;
      exp_res.push_back(32'hA + v);
      tick();
    end
    bus_if.lane_ofm_valid = 1'b0;
    chk("t4_full_valid", bus_if.res_valid, 1'b1);
    chk("t4_head_a", bus_if.res_data, 32'hA);
    chk("t4_still_stalled", bus_if.ifm_ready, 1'b0);
    bus_if.res_ready = 1'b1; bus_if.lane_ofm_valid = 1'b1; bus_if.lane_ofm = 32'hE;
    exp_res.push_back(32'hE);
    tick();
    bus_if.res_ready = 1'b0; bus_if.lane_ofm_valid = 1'b0;
    chk("t4_head_b", bus_if.res_data, 32'hB);
    bus_if.res_ready = 1'b1;
    repeat (4) tick();
    chk("t4_empty_after_4", bus_if.res_valid, 1'b0);
    wait_done(20);
    chk("t4_results", n_pops, 5);
    chk("t4_beats", n_beats, 5);

    // Zero group length: no beats, immediate completion
    lane_auto = 1;
    start_cmd(8'h77, 4, 0, 3);
    wait_done(10);
    chk("t5_done_latency", (done_cyc - acc_cyc >= 1) && (done_cyc - acc_cyc <= 2), 1'b1);
    chk("t5_no_beats", n_beats, 0);
    chk("t5_no_fires", n_fire, 0);

    // Reset in the middle of RUN, then a fresh command
    start_cmd(8'h99, 4, 2, 1);
    for (int k = 0; k < 20 && n_beats < 3; k++) tick();
    strm_on = 0; rst = 1'b1;
    tick();
    chk("t6_cmd_ready", bus_if.cmd_ready, 1'b1);
    chk("t6_res_valid", bus_if.res_valid, 1'b0);
    chk("t6_lane_valid", bus_if.lane_valid, 1'b0);
    chk("t6_lane_ifm", bus_if.lane_ifm, '0);
    rst = 1'b0;
    exp_beats.delete(); exp_res.delete(); pending = 0;
    tick();
    strm_on = 1;
    start_cmd(8'h42, 2, 1, 1);
    wait_done(40);
    chk("t6_beats", n_beats, 2);
    chk("t6_inter_ends", n_ie, 1);
    chk("t6_accum_ends", n_ae, 1);
    chk("t6_results", n_pops, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
